// File: rtl/stream_cipher_pkg.sv
// Shared types for the stream-cipher datapath: hash generator status and hash arbiter FSM states.
package stream_cipher_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        INIT   = 2'd1,
        BUSY   = 2'd2,
        READY  = 2'd3
    } hash_generator_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_ISSUE      = 2'd1,
        ARB_AWAIT_HASH = 2'd2
    } hash_arbiter_state_t;

endpackage

// File: rtl/hash_request_arbiter_if.sv
// Requester/generator side of the hash arbiter; master drives requests and generator returns, slave is the arbiter.
interface hash_request_arbiter_if
    import stream_cipher_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_pulse_in;
    hash_generator_state_t hash_generator_state;
    logic                  request_byte_pulse_out;
    logic [7:0]            hash_byte;
    logic                  hash_byte_pulse;
    logic [7:0]            routed_byte_out;
    logic [NUM_REQ-1:0]    routed_pulse_out;
    logic [ID_W-1:0]       owner_id_out;
    logic                  timeout_err_pulse_out;
    hash_arbiter_state_t   arbiter_state_out;

    modport master (
        output req_pulse_in, hash_generator_state, hash_byte, hash_byte_pulse,
        input  request_byte_pulse_out, routed_byte_out, routed_pulse_out,
               owner_id_out, timeout_err_pulse_out, arbiter_state_out
    );

    modport slave (
        input  req_pulse_in, hash_generator_state, hash_byte, hash_byte_pulse,
        output request_byte_pulse_out, routed_byte_out, routed_pulse_out,
               owner_id_out, timeout_err_pulse_out, arbiter_state_out
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping at N.
// Zero latency; no handshake.
module rr_priority_picker #(
    parameter  int N    = 2,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] pick
);
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit is written last and wins.
    always_comb begin
        any  = 1'b0;
        pick = ptr;
        idx  = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/hash_request_arbiter.sv
// Shares one hash generator among NUM_REQ requesters, round-robin, one request in flight, with a lost-byte watchdog.
// Request pulse to request_byte_pulse_out in 3 cycles (more while the generator is busy); returned byte routed 1 cycle later.
module hash_request_arbiter
    import stream_cipher_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nrst,
    hash_request_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    hash_arbiter_state_t state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d, grant_clear;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, next_ptr, pick;
    logic                any;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                req_q, req_d, timeout_q, timeout_d;
    logic [7:0]          rbyte_q, rbyte_d;
    logic [NUM_REQ-1:0]  rpulse_q, rpulse_d;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req  (pending_q),
        .ptr  (rr_ptr_q),
        .any  (any),
        .pick (pick)
    );

    assign next_ptr = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_clear = '0;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        req_d       = 1'b0;
        timeout_d   = 1'b0;
        rbyte_d     = rbyte_q;
        rpulse_d    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    owner_d           = pick;
                    grant_clear[pick] = 1'b1;
                    state_d           = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.hash_generator_state == GROUND || bus.hash_generator_state == READY) begin
                    req_d   = 1'b1;
                    wd_d    = WD_W'(TIMEOUT_CYCLES);
                    state_d = ARB_AWAIT_HASH;
                end
            end
            ARB_AWAIT_HASH: begin
                // A byte arriving on the watchdog's last cycle still counts as delivered.
                if (bus.hash_byte_pulse) begin
                    rbyte_d           = bus.hash_byte;
                    rpulse_d[owner_q] = 1'b1;
                    rr_ptr_d          = next_ptr;
                    state_d           = ARB_IDLE;
                end else if (wd_q == WD_W'(1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ARB_IDLE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        pending_d = (pending_q & ~grant_clear) | bus.req_pulse_in;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ARB_IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            wd_q      <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b0;
            rbyte_q   <= 8'h00;
            rpulse_q  <= '0;
        end else begin
            req_q     <= req_d;
            timeout_q <= timeout_d;
            rbyte_q   <= rbyte_d;
            rpulse_q  <= rpulse_d;
        end
    end

    assign bus.request_byte_pulse_out = req_q;
    assign bus.timeout_err_pulse_out  = timeout_q;
    assign bus.routed_byte_out        = rbyte_q;
    assign bus.routed_pulse_out       = rpulse_q;
    assign bus.owner_id_out           = owner_q;
    assign bus.arbiter_state_out      = state_q;

endmodule

// File: tb/tb_hash_request_arbiter.sv
// Bench for hash_request_arbiter: directed scenarios with literal expectations plus randomized traffic against a cycle model.
module tb_hash_request_arbiter;
    import stream_cipher_pkg::*;

    localparam int N = 2;
    localparam int T = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    hash_request_arbiter_if #(.NUM_REQ(N)) bus ();

    hash_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_tot = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting for a grant, 1 = waiting for generator, 2 = waiting for byte.
    int              m_phase, m_ptr, m_owner, m_wd;
    logic [N-1:0]    m_pend;
    logic            e_req, e_to;
    logic [7:0]      e_rbyte;
    logic [N-1:0]    e_rpulse;

    always @(posedge clk) begin : model
        int grant;
        grant = -1;
        if (!nrst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_wd = 0; m_pend = '0;
            e_req = 1'b0; e_to = 1'b0; e_rbyte = 8'h00; e_rpulse = '0;
        end else begin
            e_req = 1'b0; e_to = 1'b0; e_rpulse = '0;
            if (m_phase == 0) begin
                for (int k = 0; k < N; k++)
                    if (grant < 0 && m_pend[(m_ptr + k) % N]) grant = (m_ptr + k) % N;
                if (grant >= 0) begin
                    m_owner = grant;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus.hash_generator_state == GROUND || bus.hash_generator_state == READY) begin
                    e_req = 1'b1; m_wd = T; m_phase = 2;
                end
            end else begin
                if (bus.hash_byte_pulse) begin
                    e_rbyte = bus.hash_byte;
                    e_rpulse[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                    m_phase = 0;
                end else if (m_wd == 1) begin
                    e_to = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                    m_phase = 0;
                end else begin
                    m_wd = m_wd - 1;
                end
            end
            if (grant >= 0) m_pend[grant] = 1'b0;
            m_pend = m_pend | bus.req_pulse_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            hash_arbiter_state_t es;
            es = (m_phase == 2) ? ARB_AWAIT_HASH : (m_phase == 1) ? ARB_ISSUE : ARB_IDLE;
            check("cycle", 32'({bus.arbiter_state_out, bus.request_byte_pulse_out, bus.routed_byte_out,
                                bus.routed_pulse_out, bus.owner_id_out, bus.timeout_err_pulse_out}),
                           32'({es, e_req, e_rbyte, e_rpulse, 1'(m_owner), e_to}));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        bus.req_pulse_in = '0;
        bus.hash_byte_pulse = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic pulse_req(input logic [N-1:0] m);
        bus.req_pulse_in = m;
        tick();
        bus.req_pulse_in = '0;
    endtask

    task automatic wait_req();
        int c;
        c = 0;
        while (!bus.request_byte_pulse_out && c < 40) begin
            tick();
            c++;
        end
        if (!bus.request_byte_pulse_out) check("wait_req_timeout", 32'(bus.request_byte_pulse_out), 32'd1);
    endtask

    task automatic serve(input logic [7:0] b, input int exp_owner);
        wait_req();
        check("serve_owner", 32'(bus.owner_id_out), 32'(exp_owner));
        bus.hash_byte = b;
        bus.hash_byte_pulse = 1'b1;
        tick();
        bus.hash_byte_pulse = 1'b0;
        check("serve_rpulse", 32'(bus.routed_pulse_out), 32'(1 << exp_owner));
        check("serve_rbyte", 32'(bus.routed_byte_out), 32'(b));
    endtask

    initial begin
        int cnt;
        bus.req_pulse_in = '0;
        bus.hash_generator_state = READY;
        bus.hash_byte = 8'h00;
        bus.hash_byte_pulse = 1'b0;

        // 1: reset values and basic latency
        tick();
        do_reset();
        chk_en = 1'b1;
        check("rst_state", 32'(bus.arbiter_state_out), 32'(ARB_IDLE));
        check("rst_outs", 32'({bus.request_byte_pulse_out, bus.routed_byte_out, bus.routed_pulse_out,
                               bus.owner_id_out, bus.timeout_err_pulse_out}), 32'd0);
        pulse_req(2'b01);
        tick();
        check("t1_cycle2", 32'(bus.request_byte_pulse_out), 32'd0);
        tick();
        check("t1_cycle3", 32'(bus.request_byte_pulse_out), 32'd1);
        bus.hash_byte = 8'hA5;
        bus.hash_byte_pulse = 1'b1;
        tick();
        bus.hash_byte_pulse = 1'b0;
        check("t1_rbyte", 32'(bus.routed_byte_out), 32'h0A5);
        check("t1_rpulse", 32'(bus.routed_pulse_out), 32'd1);

        // 2: simultaneous requests, both pointer positions
        do_reset();
        pulse_req(2'b11);
        serve(8'h11, 0);
        serve(8'h22, 1);
        pulse_req(2'b01);
        serve(8'h33, 0);
        pulse_req(2'b11);
        serve(8'h44, 1);
        serve(8'h55, 0);

        // 3: generator busy holds the request in ARB_ISSUE without watchdog
        do_reset();
        bus.hash_generator_state = BUSY;
        pulse_req(2'b01);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(bus.request_byte_pulse_out) + int'(bus.timeout_err_pulse_out);
        end
        check("t3_busy_quiet", 32'(cnt), 32'd0);
        check("t3_state", 32'(bus.arbiter_state_out), 32'(ARB_ISSUE));
        bus.hash_generator_state = READY;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(bus.request_byte_pulse_out);
        end
        check("t3_one_req", 32'(cnt), 32'd1);

        // 4: watchdog expiry, then the other pending requester is granted
        do_reset();
        pulse_req(2'b11);
        wait_req();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_to_yet", 32'(bus.timeout_err_pulse_out), 32'd0);
        end
        tick();
        check("t4_to", 32'(bus.timeout_err_pulse_out), 32'd1);
        check("t4_state", 32'(bus.arbiter_state_out), 32'(ARB_IDLE));
        check("t4_no_rpulse", 32'(bus.routed_pulse_out), 32'd0);
        serve(8'h66, 1);

        // 5: stray byte in idle ignored; byte on the watchdog's last cycle accepted
        bus.hash_byte = 8'h3C;
        bus.hash_byte_pulse = 1'b1;
        tick();
        bus.hash_byte_pulse = 1'b0;
        check("t5_idle_rbyte", 32'(bus.routed_byte_out), 32'h066);
        check("t5_idle_rpulse", 32'(bus.routed_pulse_out), 32'd0);
        pulse_req(2'b01);
        wait_req();
        tick();
        tick();
        tick();
        bus.hash_byte = 8'h7E;
        bus.hash_byte_pulse = 1'b1;
        tick();
        bus.hash_byte_pulse = 1'b0;
        check("t5_edge_rpulse", 32'(bus.routed_pulse_out), 32'd1);
        check("t5_edge_rbyte", 32'(bus.routed_byte_out), 32'h07E);
        check("t5_edge_no_to", 32'(bus.timeout_err_pulse_out), 32'd0);

        // 6: reset while awaiting a byte with requester 1 pending
        pulse_req(2'b01);
        wait_req();
        pulse_req(2'b10);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("t6_state", 32'(bus.arbiter_state_out), 32'(ARB_IDLE));
        check("t6_outs", 32'({bus.request_byte_pulse_out, bus.routed_byte_out, bus.routed_pulse_out,
                              bus.owner_id_out, bus.timeout_err_pulse_out}), 32'd0);
        bus.hash_byte = 8'h99;
        bus.hash_byte_pulse = 1'b1;
        tick();
        bus.hash_byte_pulse = 1'b0;
        check("t6_late_byte", 32'(bus.routed_pulse_out), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt += int'(bus.request_byte_pulse_out);
        end
        check("t6_pending_dropped", 32'(cnt), 32'd0);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            bus.req_pulse_in = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.hash_generator_state = ($urandom_range(0, 2) != 0) ? READY
                                       : hash_generator_state_t'($urandom_range(0, 3));
            bus.hash_byte_pulse = ($urandom_range(0, 3) == 0);
            bus.hash_byte = 8'($urandom);
            nrst = ($urandom_range(0, 499) != 0);
            tick();
        end
        nrst = 1'b1;
        bus.req_pulse_in = '0;
        bus.hash_byte_pulse = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
